// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the divider initiator.
// Start/annul levels, reset level and the 2-bit div_ctrl state type.
package div_ctrl_pkg;

    localparam logic        DIV_START        = 1'b1;
    localparam logic        DIV_STOP         = 1'b0;
    localparam logic        DIV_RESULT_READY = 1'b1;
    localparam logic        RST_ENABLE       = 1'b1;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;

    localparam int CYC_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage initiator for the multi-cycle divider: latches operands, runs the start/annul
// handshake, stalls EX until HI/LO are captured, and aborts a hung divide after a timeout.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DRAIN_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_req_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        ex_advance_i,
    input  logic        flush_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stall_req_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o
);

    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

    div_state_t       state;
    logic [CYC_W-1:0] cyc_cnt;
    logic [DRN_W-1:0] drn_cnt;
    logic             abort_q;

    // A timed-out instruction is released at once; a flushed slot keeps a new request stalled.
    assign stall_req_o = ex_div_req_i & ~flush_i &
                         ((state == IDLE) | (state == ISSUE) | ((state == DRAIN) & ~abort_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            drn_cnt      <= '0;
            abort_q      <= 1'b0;
            div_start_o  <= DIV_STOP;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= ZERO_WORD;
            div_op2_o    <= ZERO_WORD;
            hilo_we_o    <= 1'b0;
            hi_o         <= ZERO_WORD;
            lo_o         <= ZERO_WORD;
            err_o        <= 1'b0;
        end else begin
            hilo_we_o <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_div_req_i && !flush_i) begin
                        div_op1_o    <= ex_op1_i;
                        div_op2_o    <= ex_op2_i;
                        div_signed_o <= ex_signed_i;
                        div_start_o  <= DIV_START;
                        cyc_cnt      <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush_i) begin
                        div_start_o <= DIV_STOP;
                        div_annul_o <= 1'b1;
                        drn_cnt     <= '0;
                        abort_q     <= 1'b0;
                        state       <= DRAIN;
                    end else if (div_ready_i == DIV_RESULT_READY) begin
                        hi_o        <= div_result_i[63:32];
                        lo_o        <= div_result_i[31:0];
                        hilo_we_o   <= 1'b1;
                        div_start_o <= DIV_STOP;
                        state       <= DONE;
                    end else if (cyc_cnt == CYC_W'(TIMEOUT_CYCLES - 1)) begin
                        div_start_o <= DIV_STOP;
                        div_annul_o <= 1'b1;
                        err_o       <= 1'b1;
                        drn_cnt     <= '0;
                        abort_q     <= 1'b1;
                        state       <= DRAIN;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (flush_i || ex_advance_i) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    div_annul_o <= 1'b0;
                    // After an abort, park in DONE unless EX already moved past the hung instruction.
                    if (drn_cnt == DRN_W'(DRAIN_CYCLES)) begin
                        state   <= (abort_q && !ex_advance_i && !flush_i) ? DONE : IDLE;
                        abort_q <= 1'b0;
                    end else begin
                        drn_cnt <= drn_cnt + 1'b1;
                        if (ex_advance_i || flush_i) begin
                            abort_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
